// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// A single 32-step shift/add (multiply) or shift/subtract (restoring divide) datapath
// works on operand magnitudes. Signs are corrected when the result is written.
// Divide-by-zero, signed overflow and unsupported opcodes finish in one cycle.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_FIN = 2'd2} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  op_q;
  logic        mul_q;
  logic        neg_q;
  logic [31:0] opnd_q;   // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [31:0] hi_q;     // product high half (mul) or partial remainder (div)
  logic [31:0] lo_q;     // multiplier shifting out (mul) or dividend/quotient (div)
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic        a_sgn_s, b_sgn_s, valid_s, is_div_s;
  logic        sa_s, sb_s, neg_in_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        special_s;
  logic [31:0] special_res_s;

  logic [32:0] sum_s, rsh_s;
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod_s, prod_fix_s;
  logic [31:0] q_fix_s, r_fix_s, fin_res_s;

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

  // Decode the incoming request: operand signedness, magnitudes and one-cycle special cases.
  always_comb begin
    a_sgn_s  = 1'b0;
    b_sgn_s  = 1'b0;
    valid_s  = 1'b0;
    is_div_s = 1'b0;
    case (SELECT)
      OP_MUL, OP_MULH: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; valid_s = 1'b1; end
      OP_MULHSU:       begin a_sgn_s = 1'b1; valid_s = 1'b1; end
      OP_MULHU:        begin valid_s = 1'b1; end
      OP_DIV, OP_REM:  begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; valid_s = 1'b1; is_div_s = 1'b1; end
      OP_DIVU, OP_REMU: begin valid_s = 1'b1; is_div_s = 1'b1; end
      default:         begin valid_s = 1'b0; end
    endcase

    sa_s    = a_sgn_s & DATA1[31];
    sb_s    = b_sgn_s & DATA2[31];
    mag_a_s = sa_s ? (~DATA1 + 32'd1) : DATA1;
    mag_b_s = sb_s ? (~DATA2 + 32'd1) : DATA2;
    // Remainder follows the dividend sign; products and quotients follow the sign XOR.
    if (SELECT == OP_REM) begin
      neg_in_s = sa_s;
    end else begin
      neg_in_s = sa_s ^ sb_s;
    end

    if (!valid_s) begin
      special_s     = 1'b1;
      special_res_s = 32'd0;
    end else if (is_div_s && (DATA2 == 32'd0)) begin
      special_s     = 1'b1;
      special_res_s = ((SELECT == OP_DIV) || (SELECT == OP_DIVU)) ? 32'hFFFF_FFFF : DATA1;
    end else if (((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                 (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = (SELECT == OP_DIV) ? 32'h8000_0000 : 32'd0;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'd0;
    end
  end

  // One iteration of the shared datapath, plus the sign-corrected final result.
  always_comb begin
    sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    rsh_s = {hi_q, lo_q[31]};
    if (mul_q) begin
      hi_d = sum_s[32:1];
      lo_d = {sum_s[0], lo_q[31:1]};
    end else if (rsh_s >= {1'b0, opnd_q}) begin
      // The partial remainder is below twice the divisor, so the 32-bit difference is exact.
      hi_d = rsh_s[31:0] - opnd_q;
      lo_d = {lo_q[30:0], 1'b1};
    end else begin
      hi_d = rsh_s[31:0];
      lo_d = {lo_q[30:0], 1'b0};
    end

    prod_s     = {hi_d, lo_d};
    prod_fix_s = neg_q ? (~prod_s + 64'd1) : prod_s;
    q_fix_s    = neg_q ? (~lo_d + 32'd1) : lo_d;
    r_fix_s    = neg_q ? (~hi_d + 32'd1) : hi_d;

    case (op_q)
      OP_MUL:                       fin_res_s = prod_fix_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res_s = prod_fix_s[63:32];
      OP_DIV, OP_DIVU:              fin_res_s = q_fix_s;
      OP_REM, OP_REMU:              fin_res_s = r_fix_s;
      default:                      fin_res_s = 32'd0;
    endcase
  end

  // Control FSM with registered BUSY/DONE/RESULT; accepts in IDLE or FIN, ignores START in CALC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 5'd0;
      mul_q    <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            if (special_s) begin
              state_q  <= ST_FIN;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= special_res_s;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= 5'd0;
              op_q    <= SELECT;
              mul_q   <= ~is_div_s;
              neg_q   <= neg_in_s;
              hi_q    <= 32'd0;
              opnd_q  <= is_div_s ? mag_b_s : mag_a_s;
              lo_q    <= is_div_s ? mag_a_s : mag_b_s;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_res_s;
          end else begin
            state_q <= ST_CALC;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Arithmetic reference model of every opcode.
  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint      sa = {{32{a[31]}}, a};
    longint      sb = {{32{b[31]}}, b};
    longint      ub = {32'd0, b};
    longint      p;
    logic [63:0] pu;
    int          ia = a;
    int          ib = b;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sel)
      5'd11: begin p = sa * sb; return p[31:0]; end
      5'd12: begin p = sa * sb; return p[63:32]; end
      5'd13: begin p = sa * ub; return p[63:32]; end
      5'd14: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      5'd15: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      5'd16: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd17: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return ia % ib;
      end
      5'd18: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (sel < 5'd11 || sel > 5'd18) return 1'b1;
    if (sel >= 5'd15 && b == 32'd0) return 1'b1;
    if ((sel == 5'd15 || sel == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one operation, scramble the inputs after accept, and check result, latency and BUSY.
  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp = ref_result(sel, a, b);
    int          exp_lat = is_special(sel, a, b) ? 1 : 33;
    int          lat = 0;
    int          busy_n = 0;
    int          both_n = 0;
    logic [31:0] got = 32'd0;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    #1;
    START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      if (BUSY && DONE) both_n++;
      if (DONE) begin
        lat = n;
        got = RESULT;
        break;
      end
    end
    check({tag, " result"}, got, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    check({tag, " busy&done"}, 32'(both_n), 32'd0);
  endtask

  initial begin
    int          lat;
    int          done_n;
    int          hold_bad;
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic        busy1;

    RESET = 1'b1; START = 1'b0; SELECT = 5'd0; DATA1 = 32'd0; DATA2 = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset DONE", 32'(DONE), 32'd0);
    check("reset RESULT", RESULT, 32'd0);
    RESET = 1'b0;

    // Multiply set
    run_op("MUL 10x20", 5'd11, 32'h10, 32'h20);
    run_op("MUL -1x2", 5'd11, 32'hFFFF_FFFF, 32'd2);
    run_op("MULH min*min", 5'd12, 32'h8000_0000, 32'h8000_0000);
    run_op("MULHSU", 5'd13, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("MULHU max*max", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Divide set
    run_op("DIV 100/10", 5'd15, 32'h100, 32'h10);
    run_op("DIV -16/2", 5'd15, 32'hFFFF_FFF0, 32'd2);
    run_op("DIVU", 5'd16, 32'hFFFF_FFF0, 32'd2);
    run_op("REM 17/5", 5'd17, 32'h17, 32'd5);
    run_op("REM -7/5", 5'd17, 32'hFFFF_FFF9, 32'd5);
    run_op("REMU 17/5", 5'd18, 32'h17, 32'd5);
    // Special cases
    run_op("DIV by 0", 5'd15, 32'h1234, 32'd0);
    run_op("REMU by 0", 5'd18, 32'h1234, 32'd0);
    run_op("DIV ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REM ovf", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("bad SELECT", 5'b11111, 32'h5, 32'h7);
    run_op("MULHU pre-reset", 5'd14, 32'hDEAD_BEEF, 32'hCAFE_F00D);

    // Reset in the middle of a MULHU
    @(negedge CLK);
    START = 1'b1; SELECT = 5'd14; DATA1 = 32'hFFFF_FFFF; DATA2 = 32'h1234_5678;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("midreset BUSY", 32'(BUSY), 32'd0);
    check("midreset DONE", 32'(DONE), 32'd0);
    check("midreset RESULT", RESULT, 32'd0);
    done_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (DONE || BUSY) done_n++;
    end
    check("midreset quiet", 32'(done_n), 32'd0);
    run_op("after reset", 5'd11, 32'd7, 32'd9);

    // RESET and START in the same cycle: the request is dropped
    @(negedge CLK);
    START = 1'b1; RESET = 1'b1; SELECT = 5'd15; DATA1 = 32'd8; DATA2 = 32'd0;
    @(posedge CLK);
    #1 START = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    check("reset+start DONE", 32'(DONE), 32'd0);
    check("reset+start BUSY", 32'(BUSY), 32'd0);

    // START pulse with new operands during CALC is ignored
    @(negedge CLK);
    START = 1'b1; SELECT = 5'd15; DATA1 = 32'h100; DATA2 = 32'h10;
    @(posedge CLK);
    #1 START = 1'b0;
    lat = 0; done_n = 0; got = 32'd0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge CLK);
      if (DONE) begin
        done_n++;
        if (lat == 0) begin lat = n; got = RESULT; end
      end
      if (n == 5) begin START = 1'b1; SELECT = 5'd11; DATA1 = 32'd7; DATA2 = 32'd9; end
      else START = 1'b0;
    end
    check("ignore START result", got, 32'h10);
    check("ignore START latency", 32'(lat), 32'd33);
    check("ignore START one DONE", 32'(done_n), 32'd1);

    // Back-to-back accept in the DONE cycle
    @(negedge CLK);
    START = 1'b1; SELECT = 5'd11; DATA1 = 32'h10; DATA2 = 32'h20;
    @(posedge CLK);
    #1 START = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (DONE) begin lat = n; break; end
    end
    check("b2b first latency", 32'(lat), 32'd33);
    START = 1'b1; SELECT = 5'd16; DATA1 = 32'hFFFF_FFF0; DATA2 = 32'd2;
    @(posedge CLK);
    #1 START = 1'b0;
    lat = 0; hold_bad = 0; got = 32'd0; busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 1) busy1 = BUSY;
      if (DONE) begin lat = n; got = RESULT; break; end
      if (RESULT !== 32'h200) hold_bad++;
    end
    check("b2b busy rises", 32'(busy1), 32'd1);
    check("b2b result held", 32'(hold_bad), 32'd0);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second result", got, 32'h7FFF_FFF8);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      sel = 5'(11 + $urandom_range(7, 0));
      if ($urandom_range(15, 0) == 0) sel = 5'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: b = 32'($urandom_range(15, 1));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(255, 0));
        default: ;
      endcase
      run_op($sformatf("rand%0d sel=%0d", i, sel), sel, a, b);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
